// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C master between NUM_REQ requesters.
// Provides a per-transaction watchdog that aborts a stuck master with a timeout response.
module i2c_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_dev_addr,
  input  logic [8*NUM_REQ-1:0]   req_reg_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   rsp_nack,
  output logic                   rsp_timeout,
  output logic                   m_enable,
  output logic                   m_read_write,
  output logic [6:0]             m_device_address,
  output logic [7:0]             m_register_address,
  output logic [7:0]             m_mosi_data,
  input  logic [7:0]             m_miso_data,
  input  logic                   m_busy,
  input  logic                   m_slave_nack
);
  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int CW    = IDX_W + 1;
  localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d, owner_q, owner_d;
  logic [19:0]        wd_q, wd_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_nack_q, rsp_nack_d, rsp_timeout_q, rsp_timeout_d;
  logic               m_enable_q, m_enable_d, m_rw_q, m_rw_d;
  logic [6:0]         m_dev_q, m_dev_d;
  logic [7:0]         m_reg_q, m_reg_d, m_mosi_q, m_mosi_d;

  logic [CW-1:0]      cand;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [19:0]        wd_inc;
  logic               wd_hit;

  assign wd_inc = (wd_q == '1) ? wd_q : wd_q + 20'd1;
  // Abort on the cycle the counter would reach TIMEOUT_CYCLES-1.
  assign wd_hit = (wd_q >= WD_LAST);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    wd_d          = wd_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rsp_nack_d    = rsp_nack_q;
    rsp_timeout_d = rsp_timeout_q;
    m_enable_d    = m_enable_q;
    m_rw_d        = m_rw_q;
    m_dev_d       = m_dev_q;
    m_reg_d       = m_reg_q;
    m_mosi_d      = m_mosi_q;

    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (!m_busy && win_found) begin
          req_ready_d[win_idx] = 1'b1;
          m_rw_d     = req_rw[win_idx];
          m_dev_d    = req_dev_addr[7*win_idx +: 7];
          m_reg_d    = req_reg_addr[8*win_idx +: 8];
          m_mosi_d   = req_wdata[8*win_idx +: 8];
          owner_d    = win_idx;
          last_d     = win_idx;
          m_enable_d = 1'b1;
          wd_d       = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE, WAIT_DONE: begin
        wd_d = wd_inc;
        if (wd_hit) begin
          m_enable_d           = 1'b0;
          rsp_timeout_d        = 1'b1;
          rsp_nack_d           = 1'b0;
          rsp_data_d           = 8'h00;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end else if (state_q == ISSUE) begin
          if (m_busy) begin
            m_enable_d = 1'b0;
            state_d    = WAIT_DONE;
          end
        end else if (!m_busy) begin
          rsp_data_d           = m_miso_data;
          rsp_nack_d           = m_slave_nack;
          rsp_timeout_d        = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      last_q        <= IDX_W'(NUM_REQ - 1);
      owner_q       <= '0;
      wd_q          <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      m_enable_q    <= 1'b0;
      m_rw_q        <= 1'b0;
      m_dev_q       <= '0;
      m_reg_q       <= '0;
      m_mosi_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      wd_q          <= wd_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_nack_q    <= rsp_nack_d;
      rsp_timeout_q <= rsp_timeout_d;
      m_enable_q    <= m_enable_d;
      m_rw_q        <= m_rw_d;
      m_dev_q       <= m_dev_d;
      m_reg_q       <= m_reg_d;
      m_mosi_q      <= m_mosi_d;
    end
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_nack           = rsp_nack_q;
  assign rsp_timeout        = rsp_timeout_q;
  assign m_enable           = m_enable_q;
  assign m_read_write       = m_rw_q;
  assign m_device_address   = m_dev_q;
  assign m_register_address = m_reg_q;
  assign m_mosi_data        = m_mosi_q;
endmodule
